// File: rtl/vga_pkg.sv
// vga_pkg: raster timing constants and scheduler state encoding shared across the VGA renderer
package vga_pkg;
  localparam int COORD_W  = 10;
  localparam int H_OFFSET = 144;
  localparam int V_OFFSET = 35;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} sched_state_t;
endpackage

// File: rtl/sprite_row_match.sv
// sprite_row_match: decides whether a descriptor covers the target line and which of its rows it is
module sprite_row_match
  import vga_pkg::*;
(
  input  logic [COORD_W:0]   target,
  input  logic [COORD_W-1:0] obj_y,
  input  logic [COORD_W-1:0] obj_h,
  input  logic               obj_en,
  output logic               hit,
  output logic [COORD_W-1:0] row
);
  logic [COORD_W:0] y_end;
  // 11-bit bounds so y+h never wraps; h=0 gives an empty interval
  always_comb begin
    y_end = {1'b0, obj_y} + {1'b0, obj_h};
    hit   = obj_en && (target >= {1'b0, obj_y}) && (target < y_end);
    row   = target[COORD_W-1:0] - obj_y;
  end
endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: picks up to N_SLOTS objects for the next scanline during horizontal blanking
module sprite_line_scheduler
  import vga_pkg::*;
#(
  parameter  int N_OBJ    = 16,
  parameter  int N_SLOTS  = 4,
  parameter  int H_OFFSET = vga_pkg::H_OFFSET,
  parameter  int V_OFFSET = vga_pkg::V_OFFSET,
  parameter  int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter  int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter  int H_TOTAL  = vga_pkg::H_TOTAL,
  localparam int IDW      = $clog2(N_OBJ)
) (
  input  logic                       VGA_CLK,
  input  logic                       reset,
  input  logic                       ativo,
  input  logic [COORD_W-1:0]         VGA_X,
  input  logic [COORD_W-1:0]         VGA_Y,
  output logic [IDW-1:0]             obj_rd_idx,
  input  logic [COORD_W-1:0]         obj_x,
  input  logic [COORD_W-1:0]         obj_y,
  input  logic [COORD_W-1:0]         obj_h,
  input  logic                       obj_en,
  output logic [N_SLOTS-1:0]         slot_valid,
  output logic [COORD_W*N_SLOTS-1:0] slot_x,
  output logic [COORD_W*N_SLOTS-1:0] slot_row,
  output logic [IDW*N_SLOTS-1:0]     slot_id,
  output logic                       line_overflow,
  output logic                       busy
);
  localparam int CNTW = $clog2(N_OBJ + 1);
  localparam int SCW  = $clog2(N_SLOTS + 1);
  localparam logic [COORD_W-1:0] TRIG_X = COORD_W'(H_OFFSET + H_ACTIVE);
  localparam logic [COORD_W:0] V_LO = (COORD_W + 1)'(V_OFFSET);
  localparam logic [COORD_W:0] V_HI = (COORD_W + 1)'(V_OFFSET + V_ACTIVE);
  // The whole scan plus commit must fit inside horizontal blanking
  if (N_OBJ + 3 >= H_TOTAL - H_ACTIVE) begin : g_too_many_obj
    $error("sprite_line_scheduler: N_OBJ too large to scan within horizontal blanking");
  end
  sched_state_t         state;
  logic [CNTW-1:0]      cnt;
  logic [COORD_W:0]     target;
  logic [COORD_W:0]     y_next;
  logic                 line_live;
  logic                 eval_v;
  logic [IDW-1:0]       eval_idx;
  logic                 obj_hit;
  logic                 hit_now;
  logic [COORD_W-1:0]   row;
  logic [COORD_W-1:0]   sh_x   [N_SLOTS];
  logic [COORD_W-1:0]   sh_row [N_SLOTS];
  logic [IDW-1:0]       sh_id  [N_SLOTS];
  logic [SCW-1:0]       sh_count;
  logic                 sh_ovf;
  assign y_next  = {1'b0, VGA_Y} + 1'b1;
  assign hit_now = eval_v && line_live && obj_hit;
  assign busy    = state != IDLE;
  sprite_row_match u_match (
    .target (target),
    .obj_y  (obj_y),
    .obj_h  (obj_h),
    .obj_en (obj_en),
    .hit    (obj_hit),
    .row    (row)
  );
  // Scan FSM: index counter, one-cycle descriptor pipeline, shadow fill and end-of-scan commit
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      target        <= '0;
      line_live     <= 1'b0;
      eval_v        <= 1'b0;
      eval_idx      <= '0;
      obj_rd_idx    <= '0;
      sh_count      <= '0;
      sh_ovf        <= 1'b0;
      slot_valid    <= '0;
      slot_x        <= '0;
      slot_row      <= '0;
      slot_id       <= '0;
      line_overflow <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
        sh_x[i]   <= '0;
        sh_row[i] <= '0;
        sh_id[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: if (VGA_X == TRIG_X) begin
          state      <= SCAN;
          target     <= y_next - V_LO;
          line_live  <= (y_next >= V_LO) && (y_next < V_HI) && ativo;
          cnt        <= '0;
          obj_rd_idx <= '0;
          eval_v     <= 1'b0;
        end
        SCAN: begin
          cnt        <= cnt + 1'b1;
          obj_rd_idx <= cnt[IDW-1:0] + 1'b1;
          eval_v     <= cnt < CNTW'(N_OBJ);
          eval_idx   <= cnt[IDW-1:0];
          for (int i = 0; i < N_SLOTS; i++)
            if (hit_now && sh_count == SCW'(i)) begin
              sh_x[i]   <= obj_x;
              sh_row[i] <= row;
              sh_id[i]  <= eval_idx;
            end
          if (hit_now && sh_count == SCW'(N_SLOTS)) sh_ovf <= 1'b1;
          else if (hit_now) sh_count <= sh_count + 1'b1;
          if (cnt == CNTW'(N_OBJ)) state <= COMMIT;
        end
        COMMIT: begin
          state         <= IDLE;
          eval_v        <= 1'b0;
          obj_rd_idx    <= '0;
          line_overflow <= sh_ovf;
          sh_ovf        <= 1'b0;
          sh_count      <= '0;
          for (int i = 0; i < N_SLOTS; i++) begin
            slot_valid[i]                   <= sh_count > SCW'(i);
            slot_x[COORD_W*i +: COORD_W]    <= sh_x[i];
            slot_row[COORD_W*i +: COORD_W]  <= sh_row[i];
            slot_id[IDW*i +: IDW]           <= sh_id[i];
            sh_x[i]                         <= '0;
            sh_row[i]                       <= '0;
            sh_id[i]                        <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed line-by-line checks of slot selection, boundaries, reset and stability
module tb_sprite_line_scheduler;
  logic        VGA_CLK = 1'b0;
  logic        reset = 1'b1;
  logic        ativo = 1'b1;
  logic [9:0]  VGA_X = '0;
  logic [9:0]  VGA_Y = '0;
  logic [3:0]  obj_rd_idx;
  logic [9:0]  obj_x = '0;
  logic [9:0]  obj_y = '0;
  logic [9:0]  obj_h = '0;
  logic        obj_en = 1'b0;
  logic [3:0]  slot_valid;
  logic [39:0] slot_x;
  logic [39:0] slot_row;
  logic [15:0] slot_id;
  logic        line_overflow;
  logic        busy;
  logic [9:0]  tx [16];
  logic [9:0]  ty [16];
  logic [9:0]  th [16];
  logic        ten [16];
  logic [3:0]  s_valid;
  logic [39:0] s_x;
  logic [39:0] s_row;
  logic [15:0] s_id;
  logic        s_ovf;
  int          n_chk = 0;
  int          n_fail = 0;
  sprite_line_scheduler dut (
    .VGA_CLK       (VGA_CLK),
    .reset         (reset),
    .ativo         (ativo),
    .VGA_X         (VGA_X),
    .VGA_Y         (VGA_Y),
    .obj_rd_idx    (obj_rd_idx),
    .obj_x         (obj_x),
    .obj_y         (obj_y),
    .obj_h         (obj_h),
    .obj_en        (obj_en),
    .slot_valid    (slot_valid),
    .slot_x        (slot_x),
    .slot_row      (slot_row),
    .slot_id       (slot_id),
    .line_overflow (line_overflow),
    .busy          (busy)
  );
  always #5 VGA_CLK = ~VGA_CLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_slots(input string tag, input logic [3:0] v, input logic [39:0] x,
                              input logic [39:0] r, input logic [15:0] id, input logic ovf);
    check({tag, ".valid"}, 64'(s_valid), 64'(v));
    check({tag, ".x"}, 64'(s_x), 64'(x));
    check({tag, ".row"}, 64'(s_row), 64'(r));
    check({tag, ".id"}, 64'(s_id), 64'(id));
    check({tag, ".ovf"}, 64'(s_ovf), 64'(ovf));
  endtask
  // One raster line; the descriptor table answers one cycle after obj_rd_idx.
  // ev: 1 = pulse reset at ev_x, 2 = drop ativo at ev_x.
  task automatic line(input int y, input int ev_x, input int ev);
    int   ri;
    logic moved;
    moved = 1'b0;
    for (int x = 0; x < 800; x++) begin
      ri = int'(obj_rd_idx);
      @(posedge VGA_CLK);
      #1;
      VGA_X  = 10'(x);
      VGA_Y  = 10'(y);
      obj_x  = tx[ri];
      obj_y  = ty[ri];
      obj_h  = th[ri];
      obj_en = ten[ri];
      if (x == 144) begin
        s_valid = slot_valid;
        s_x     = slot_x;
        s_row   = slot_row;
        s_id    = slot_id;
        s_ovf   = line_overflow;
        check("busy_active", 64'(busy), 64'd0);
      end else if (x > 144 && x < 784 &&
                   {slot_valid, slot_x, slot_row, slot_id, line_overflow} !== {s_valid, s_x, s_row, s_id, s_ovf})
        moved = 1'b1;
      if (x == ev_x && ev == 1) begin
        check("busy_scan", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("rst.valid", 64'(slot_valid), 64'd0);
        check("rst.x", 64'(slot_x), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.idx", 64'(obj_rd_idx), 64'd0);
        #1;
        reset = 1'b0;
      end
      if (x == ev_x && ev == 2) ativo = 1'b0;
    end
    check("stable", 64'(moved), 64'd0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      tx[i] = 10'(10 * i); ty[i] = 10'd200; th[i] = 10'd10; ten[i] = 1'b0;
    end
    ten[0] = 1'b1; th[0] = 10'd0;
    ten[1] = 1'b1; th[1] = 10'd20;
    ten[2] = 1'b1; th[2] = 10'd20;
    ten[3] = 1'b1; tx[3] = 10'd100; ty[3] = 10'd50; th[3] = 10'd51;
    ten[4] = 1'b0; th[4] = 10'd50;
    ten[5] = 1'b1; ten[7] = 1'b1; ten[9] = 1'b1;
    ten[10] = 1'b1; tx[10] = 10'd300; ty[10] = 10'd0; th[10] = 10'd5;
    ten[11] = 1'b1; tx[11] = 10'd5; ty[11] = 10'd479; th[11] = 10'd10;
    #12;
    check("reset.valid", 64'(slot_valid), 64'd0);
    check("reset.row", 64'(slot_row), 64'd0);
    check("reset.id", 64'(slot_id), 64'd0);
    check("reset.ovf", 64'(line_overflow), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    reset = 1'b0;
    line(84, -1, 0);
    line(84, 790, 1);
    expect_slots("t50", 4'b0001, 40'd100, 40'd0, 16'h0003, 1'b0);
    line(134, -1, 0);
    expect_slots("killed", 4'b0000, 40'd0, 40'd0, 16'h0000, 1'b0);
    line(135, -1, 0);
    expect_slots("t100", 4'b0001, 40'd100, 40'd50, 16'h0003, 1'b0);
    line(239, -1, 0);
    expect_slots("t101", 4'b0000, 40'd0, 40'd0, 16'h0000, 1'b0);
    line(249, -1, 0);
    expect_slots("t205", 4'b1111, {10'd70, 10'd50, 10'd20, 10'd10}, {4{10'd5}}, 16'h7521, 1'b1);
    line(33, -1, 0);
    expect_slots("t215", 4'b0011, {20'd0, 10'd20, 10'd10}, {20'd0, 10'd15, 10'd15}, 16'h0021, 1'b0);
    line(34, -1, 0);
    expect_slots("y33", 4'b0000, 40'd0, 40'd0, 16'h0000, 1'b0);
    line(513, -1, 0);
    expect_slots("t0", 4'b0001, 40'd300, 40'd0, 16'h000a, 1'b0);
    line(514, -1, 0);
    expect_slots("t479", 4'b0001, 40'd5, 40'd0, 16'h000b, 1'b0);
    line(239, -1, 0);
    expect_slots("y514", 4'b0000, 40'd0, 40'd0, 16'h0000, 1'b0);
    line(239, 790, 2);
    expect_slots("t205b", 4'b1111, {10'd70, 10'd50, 10'd20, 10'd10}, {4{10'd5}}, 16'h7521, 1'b1);
    line(239, -1, 0);
    expect_slots("ativo_fall", 4'b1111, {10'd70, 10'd50, 10'd20, 10'd10}, {4{10'd5}}, 16'h7521, 1'b1);
    line(84, -1, 0);
    expect_slots("ativo_off", 4'b0000, 40'd0, 40'd0, 16'h0000, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
